// File: rtl/mem_pkg.sv
// Shared memory-control codes, FSM encoding and access-legality helpers for the MEM stage.
package mem_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned LANES  = 4;
  localparam int unsigned LAT_W  = 3;

  // MemWriteM byte-strobe codes
  localparam logic [3:0] MEMW_NONE = 4'b0000;
  localparam logic [3:0] MEMW_BYTE = 4'b0001;
  localparam logic [3:0] MEMW_HALF = 4'b0011;
  localparam logic [3:0] MEMW_WORD = 4'b1111;

  // MemReadM size codes
  localparam logic [1:0] MEMR_WORD = 2'd0;
  localparam logic [1:0] MEMR_BYTE = 2'd1;
  localparam logic [1:0] MEMR_HALF = 2'd2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_WAIT = 2'd1,
    LOAD_DONE = 2'd2
  } state_e;

  // Load attributes captured at accept time and replayed when bank data returns
  typedef struct packed {
    logic [1:0] lane;
    logic [1:0] size;
    logic       uns;
    logic       err;
  } load_ctl_t;

  // Legal size code and natural alignment for a load
  function automatic logic load_ok(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      MEMR_WORD: load_ok = (lane == 2'b00);
      MEMR_BYTE: load_ok = 1'b1;
      MEMR_HALF: load_ok = ~lane[0];
      default:   load_ok = 1'b0;
    endcase
  endfunction

  // Legal strobe code and natural alignment for a store
  function automatic logic store_ok(input logic [3:0] code, input logic [1:0] lane);
    case (code)
      MEMW_WORD: store_ok = (lane == 2'b00);
      MEMW_BYTE: store_ok = 1'b1;
      MEMW_HALF: store_ok = ~lane[0];
      default:   store_ok = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_unit_load_extend.sv
// Selects the addressed byte/half of a bank word and sign- or zero-extends it to 32 bits.
module load_extend
  import mem_pkg::*;
(
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        lane,
  input  logic [1:0]        size,
  input  logic              uns,
  output logic [DATA_W-1:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane extraction (little-endian) followed by extension to full width
  always_comb begin
    byte_sel = rdata[7:0];
    half_sel = lane[1] ? rdata[31:16] : rdata[15:0];
    case (lane)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    case (size)
      MEMR_BYTE: result = uns ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      MEMR_HALF: result = uns ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default:   result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_unit.sv
// MEM-stage access unit: store lane steering, load sequencing over banked memory, load extension.
module mem_stage_unit
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              inicio,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        MemWriteM,
  input  logic [1:0]        MemReadM,
  input  logic              MemtoRegM,
  input  logic              LoadUnsignedM,
  input  logic [31:0]       AddrM,
  input  logic [31:0]       WriteDataM,
  output logic [ADDR_W-1:0] bank_addr,
  output logic [3:0]        bank_we,
  output logic [31:0]       bank_wdata,
  input  logic [31:0]       bank_rdata,
  output logic [31:0]       ReadDataM,
  output logic              rd_valid,
  output logic              StallM,
  output logic              misalign_err
);

  state_e            state_q, state_d;
  logic [LAT_W-1:0]  cnt_q, cnt_d;
  load_ctl_t         ctl_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       rdata_q;
  logic              rd_valid_q;
  logic              err_q;

  logic [1:0]        lane;
  logic              idle;
  logic              is_store;
  logic              load_legal;
  logic              store_legal;
  logic              acc_load;
  logic              acc_store;
  logic              bad_req;
  logic              capture;
  logic              stall_c;
  logic [3:0]        we_c;
  logic [31:0]       wdata_c;
  logic [31:0]       ext_data;
  logic              unused_addr_hi;

  // Address bits above the bank word index are deliberately dropped (wrap-around)
  assign unused_addr_hi = ^AddrM[31:ADDR_W+2];

  // Request classification and acceptance
  always_comb begin
    lane        = AddrM[1:0];
    idle        = (state_q == IDLE);
    is_store    = ~MemtoRegM && (MemWriteM != MEMW_NONE);
    load_legal  = (MemWriteM == MEMW_NONE) && load_ok(MemReadM, lane);
    store_legal = store_ok(MemWriteM, lane);
    acc_load    = idle && req_valid && MemtoRegM;
    acc_store   = idle && req_valid && is_store;
    bad_req     = (acc_load && ~load_legal) || (acc_store && ~store_legal);
  end

  // Store lane steering: strobe shifted to the lane, data replicated across lanes
  always_comb begin
    we_c    = 4'b0000;
    wdata_c = WriteDataM;
    case (MemWriteM)
      MEMW_BYTE: begin
        we_c    = 4'b0001 << lane;
        wdata_c = {4{WriteDataM[7:0]}};
      end
      MEMW_HALF: begin
        we_c    = 4'b0011 << {lane[1], 1'b0};
        wdata_c = {2{WriteDataM[15:0]}};
      end
      MEMW_WORD: begin
        we_c    = 4'b1111;
        wdata_c = WriteDataM;
      end
      default: begin
        we_c    = 4'b0000;
        wdata_c = WriteDataM;
      end
    endcase
  end

  // Next-state, latency countdown and handshake outputs
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    capture   = 1'b0;
    stall_c   = 1'b0;
    req_ready = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (acc_load) begin
          state_d = LOAD_WAIT;
          cnt_d   = LAT_W'(RD_LAT);
          stall_c = 1'b1;
        end
      end
      LOAD_WAIT: begin
        stall_c = 1'b1;
        cnt_d   = cnt_q - LAT_W'(1);
        if (cnt_q <= LAT_W'(1)) begin
          capture = 1'b1;
          state_d = LOAD_DONE;
        end
      end
      LOAD_DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Bank-side outputs; reset forces them quiet without waiting for a clock
  always_comb begin
    bank_we    = 4'b0000;
    bank_wdata = 32'd0;
    bank_addr  = idle ? AddrM[ADDR_W+1:2] : addr_q;
    StallM     = stall_c & ~inicio;
    if (acc_store && store_legal && ~inicio) begin
      bank_we    = we_c;
      bank_wdata = wdata_c;
    end
    if (inicio) begin
      bank_addr = '0;
    end
  end

  // FSM state and latency counter
  always_ff @(posedge clk or posedge inicio) begin
    if (inicio) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Hold the load's word address and extraction attributes for the whole access
  always_ff @(posedge clk or posedge inicio) begin
    if (inicio) begin
      ctl_q  <= '0;
      addr_q <= '0;
    end else if (acc_load) begin
      ctl_q.lane <= lane;
      ctl_q.size <= MemReadM;
      ctl_q.uns  <= LoadUnsignedM;
      ctl_q.err  <= ~load_legal;
      addr_q     <= AddrM[ADDR_W+1:2];
    end
  end

  load_extend u_load_extend (
    .rdata  (bank_rdata),
    .lane   (ctl_q.lane),
    .size   (ctl_q.size),
    .uns    (ctl_q.uns),
    .result (ext_data)
  );

  // Load result register and one-cycle completion pulse; rejected loads return zero
  always_ff @(posedge clk or posedge inicio) begin
    if (inicio) begin
      rdata_q    <= 32'd0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= capture;
      if (capture) begin
        rdata_q <= ctl_q.err ? 32'd0 : ext_data;
      end
    end
  end

  // Sticky error flag for misaligned or illegal requests
  always_ff @(posedge clk or posedge inicio) begin
    if (inicio) begin
      err_q <= 1'b0;
    end else if (bad_req) begin
      err_q <= 1'b1;
    end
  end

  assign ReadDataM    = rdata_q;
  assign rd_valid     = rd_valid_q;
  assign misalign_err = err_q;

endmodule

// File: tb/tb_mem_stage_unit.sv
// Scoreboard bench for mem_stage_unit with a behavioural byte-lane bank model.
module tb_mem_stage_unit;
  import mem_pkg::*;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned RD_LAT = 1;

  logic              clk = 1'b0;
  logic              inicio;
  logic              req_valid;
  logic              req_ready;
  logic [3:0]        MemWriteM;
  logic [1:0]        MemReadM;
  logic              MemtoRegM;
  logic              LoadUnsignedM;
  logic [31:0]       AddrM;
  logic [31:0]       WriteDataM;
  logic [ADDR_W-1:0] bank_addr;
  logic [3:0]        bank_we;
  logic [31:0]       bank_wdata;
  logic [31:0]       bank_rdata;
  logic [31:0]       ReadDataM;
  logic              rd_valid;
  logic              StallM;
  logic              misalign_err;

  always #5 clk = ~clk;

  mem_stage_unit #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .clk           (clk),
    .inicio        (inicio),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .MemWriteM     (MemWriteM),
    .MemReadM      (MemReadM),
    .MemtoRegM     (MemtoRegM),
    .LoadUnsignedM (LoadUnsignedM),
    .AddrM         (AddrM),
    .WriteDataM    (WriteDataM),
    .bank_addr     (bank_addr),
    .bank_we       (bank_we),
    .bank_wdata    (bank_wdata),
    .bank_rdata    (bank_rdata),
    .ReadDataM     (ReadDataM),
    .rd_valid      (rd_valid),
    .StallM        (StallM),
    .misalign_err  (misalign_err)
  );

  // Four byte-wide banks with one-cycle registered read
  logic [31:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (bank_we[i]) mem[bank_addr][8*i +: 8] <= bank_wdata[8*i +: 8];
    end
    bank_rdata <= mem[bank_addr];
  end

  typedef struct {
    logic [3:0]        we;
    logic [31:0]       wd;
    logic [ADDR_W-1:0] ba;
  } st_exp_t;

  st_exp_t     store_q[$];
  logic [31:0] load_q[$];
  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic fail_evt(input string name);
    checks++;
    $display("FAIL %s", name);
  endtask

  // Monitor: every load completion and every bank write is matched to the scoreboard
  always @(negedge clk) begin
    if (!inicio && rd_valid) begin
      if (load_q.size() == 0) fail_evt("unexpected rd_valid");
      else chk("ReadDataM", ReadDataM, load_q.pop_front());
    end
    if (bank_we != 4'b0000) begin
      if (store_q.size() == 0) fail_evt("unexpected bank write");
      else begin
        st_exp_t e;
        e = store_q.pop_front();
        chk("bank_we", 32'(bank_we), 32'(e.we));
        chk("bank_wdata", bank_wdata, e.wd);
        chk("bank_addr", 32'(bank_addr), 32'(e.ba));
      end
    end
  end

  task automatic issue(input logic ld, input logic [3:0] mw, input logic [1:0] mr,
                       input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] exp_we);
    bit acc;
    acc = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b1; MemtoRegM = ld; MemWriteM = mw; MemReadM = mr;
    LoadUnsignedM = uns; AddrM = addr; WriteDataM = wd;
    for (int i = 0; i < 16 && !acc; i++) begin
      @(negedge clk);
      if (req_ready) acc = 1'b1;
    end
    if (!acc) fail_evt("request accept timeout");
    chk("StallM at accept", 32'(StallM), 32'(ld));
    chk("bank_we at accept", 32'(bank_we), 32'(exp_we));
    @(posedge clk); #1;
    req_valid = 1'b0; MemtoRegM = 1'b0; MemWriteM = MEMW_NONE;
  endtask

  task automatic wait_rd(input string name);
    bit seen;
    int n;
    seen = 1'b0;
    n = 0;
    for (int i = 1; i <= 8 && !seen; i++) begin
      @(negedge clk);
      if (rd_valid) begin
        seen = 1'b1;
        n = i;
      end else begin
        chk({name, " StallM during load"}, 32'(StallM), 32'd1);
        chk({name, " req_ready during load"}, 32'(req_ready), 32'd0);
      end
    end
    if (!seen) fail_evt({name, " rd_valid timeout"});
    else begin
      chk({name, " latency"}, 32'(n), 32'(RD_LAT + 1));
      chk({name, " StallM at rd_valid"}, 32'(StallM), 32'd0);
      @(negedge clk);
      chk({name, " rd_valid pulse width"}, 32'(rd_valid), 32'd0);
    end
  endtask

  task automatic do_store(input logic [31:0] addr, input logic [3:0] code, input logic [31:0] wd,
                          input logic [3:0] exp_we, input logic [31:0] exp_wd,
                          input logic [ADDR_W-1:0] exp_ba);
    st_exp_t e;
    if (exp_we != 4'b0000) begin
      e.we = exp_we; e.wd = exp_wd; e.ba = exp_ba;
      store_q.push_back(e);
    end
    issue(1'b0, code, 2'd0, 1'b0, addr, wd, exp_we);
  endtask

  task automatic do_load(input string name, input logic [31:0] addr, input logic [1:0] size,
                         input logic uns, input logic [3:0] mw, input logic [31:0] exp);
    load_q.push_back(exp);
    issue(1'b1, mw, size, uns, addr, 32'd0, 4'b0000);
    wait_rd(name);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    inicio = 1'b1; req_valid = 1'b0; MemWriteM = MEMW_NONE; MemReadM = MEMR_WORD;
    MemtoRegM = 1'b0; LoadUnsignedM = 1'b0; AddrM = 32'd0; WriteDataM = 32'd0;
    repeat (2) @(negedge clk);
    chk("reset req_ready", 32'(req_ready), 32'd1);
    chk("reset rd_valid", 32'(rd_valid), 32'd0);
    chk("reset StallM", 32'(StallM), 32'd0);
    chk("reset misalign_err", 32'(misalign_err), 32'd0);
    chk("reset ReadDataM", ReadDataM, 32'd0);
    chk("reset bank_we", 32'(bank_we), 32'd0);
    @(posedge clk); #1 inicio = 1'b0;

    // Good stores and loads with hand-computed lanes and extensions
    do_store(32'h0000_0006, MEMW_BYTE, 32'h1234_56AB, 4'b0100, 32'hABAB_ABAB, 10'd1);
    do_store(32'h0000_0004, MEMW_WORD, 32'h0000_8000, 4'b1111, 32'h0000_8000, 10'd1);
    do_load("LB 0x5", 32'h0000_0005, MEMR_BYTE, 1'b0, MEMW_NONE, 32'hFFFF_FF80);
    do_load("LBU 0x5", 32'h0000_0005, MEMR_BYTE, 1'b1, MEMW_NONE, 32'h0000_0080);
    repeat (2) @(negedge clk);
    chk("ReadDataM held", ReadDataM, 32'h0000_0080);
    do_store(32'h1000_000A, MEMW_HALF, 32'hBEEF_9A7C, 4'b1100, 32'h9A7C_9A7C, 10'd2);
    do_load("LH 0xA", 32'h0000_000A, MEMR_HALF, 1'b0, MEMW_NONE, 32'hFFFF_9A7C);
    do_load("LHU 0xA", 32'h0000_000A, MEMR_HALF, 1'b1, MEMW_NONE, 32'h0000_9A7C);
    do_store(32'h0000_0008, MEMW_WORD, 32'h1357_2468, 4'b1111, 32'h1357_2468, 10'd2);

    // Load followed by a store held on req_valid until the load drains
    begin
      st_exp_t e;
      load_q.push_back(32'h1357_2468);
      e.we = 4'b1111; e.wd = 32'hDEAD_BEEF; e.ba = 10'd3;
      store_q.push_back(e);
      issue(1'b1, MEMW_NONE, MEMR_WORD, 1'b0, 32'h0000_0008, 32'd0, 4'b0000);
      req_valid = 1'b1; MemtoRegM = 1'b0; MemWriteM = MEMW_WORD;
      AddrM = 32'h0000_000C; WriteDataM = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("b2b wait bank_we", 32'(bank_we), 32'd0);
      chk("b2b wait StallM", 32'(StallM), 32'd1);
      chk("b2b wait req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      chk("b2b done rd_valid", 32'(rd_valid), 32'd1);
      chk("b2b done req_ready", 32'(req_ready), 32'd0);
      chk("b2b done bank_we", 32'(bank_we), 32'd0);
      @(negedge clk);
      chk("b2b store req_ready", 32'(req_ready), 32'd1);
      chk("b2b store bank_we", 32'(bank_we), 32'hF);
      @(posedge clk); #1;
      req_valid = 1'b0; MemWriteM = MEMW_NONE;
    end

    do_load("LW 0xC", 32'h0000_000C, MEMR_WORD, 1'b0, MEMW_NONE, 32'hDEAD_BEEF);
    do_load("LB 0xF", 32'h0000_000F, MEMR_BYTE, 1'b0, MEMW_NONE, 32'hFFFF_FFDE);
    do_load("LHU 0xE", 32'h0000_000E, MEMR_HALF, 1'b1, MEMW_NONE, 32'h0000_DEAD);
    chk("no error after legal traffic", 32'(misalign_err), 32'd0);

    // Misaligned load drains with zero and sets the sticky error
    do_load("LH 0x3", 32'h0000_0003, MEMR_HALF, 1'b0, MEMW_NONE, 32'h0000_0000);
    chk("misalign_err after LH 0x3", 32'(misalign_err), 32'd1);
    do_load("LW after error", 32'h0000_000C, MEMR_WORD, 1'b0, MEMW_NONE, 32'hDEAD_BEEF);
    chk("misalign_err sticky", 32'(misalign_err), 32'd1);
    do_store(32'h0000_0000, 4'b0111, 32'hFFFF_FFFF, 4'b0000, 32'd0, 10'd0);

    // Request that is neither load nor store leaves the unit idle
    issue(1'b0, MEMW_NONE, MEMR_WORD, 1'b0, 32'h0000_0004, 32'd0, 4'b0000);
    chk("nop req_ready", 32'(req_ready), 32'd1);
    chk("nop StallM", 32'(StallM), 32'd0);

    // Reset in the middle of a load aborts it
    issue(1'b1, MEMW_NONE, MEMR_WORD, 1'b0, 32'h0000_000C, 32'd0, 4'b0000);
    #2 inicio = 1'b1;
    #1;
    chk("abort req_ready", 32'(req_ready), 32'd1);
    chk("abort StallM", 32'(StallM), 32'd0);
    chk("abort rd_valid", 32'(rd_valid), 32'd0);
    chk("abort misalign_err", 32'(misalign_err), 32'd0);
    chk("abort bank_addr", 32'(bank_addr), 32'd0);
    @(negedge clk); inicio = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort no rd_valid", 32'(rd_valid), 32'd0);
    end
    do_load("LW after abort", 32'h0000_000C, MEMR_WORD, 1'b0, MEMW_NONE, 32'hDEAD_BEEF);

    // Misaligned store: no bank write, error set
    do_store(32'h0000_0001, MEMW_HALF, 32'h0000_5555, 4'b0000, 32'd0, 10'd0);
    chk("misalign_err after SH 0x1", 32'(misalign_err), 32'd1);
    @(posedge clk); #1 inicio = 1'b1;
    #2 chk("misalign_err cleared", 32'(misalign_err), 32'd0);
    @(negedge clk); inicio = 1'b0;

    // Load and store codes both set, and an illegal size code
    do_load("LD+ST", 32'h0000_0004, MEMR_WORD, 1'b0, MEMW_WORD, 32'h0000_0000);
    chk("misalign_err after LD+ST", 32'(misalign_err), 32'd1);
    do_load("size 3", 32'h0000_0004, 2'd3, 1'b0, MEMW_NONE, 32'h0000_0000);

    repeat (3) @(negedge clk);
    chk("load scoreboard drained", 32'(load_q.size()), 32'd0);
    chk("store scoreboard drained", 32'(store_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
